// File: rtl/read_stage_ctrl_pkg.sv
// Read-stage issue control: shared constants and types.
// Optional feature macro: READ_STAGE_CTRL_BYPASS_EN (see read_scoreboard).
package read_stage_ctrl_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int PEND_W    = 2;

    typedef logic [REG_IDX_W-1:0] RegIdx;
    typedef logic [PEND_W-1:0]    PendCnt;

    localparam PendCnt PEND_MAX = '1;

endpackage

// File: rtl/read_scoreboard.sv
// Per-register pending-write scoreboard for the Read stage.
// Ports: clk/rst; inc_* (issue), wb_* and fl_* (decrements);
//   rs1/rs2 lookups -> *_busy_o; rd lookup -> rd_full_o.
// Macro READ_STAGE_CTRL_BYPASS_EN: a source whose last pending
//   write retires this cycle on wb_* is not reported busy.
module read_scoreboard
    import read_stage_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc_en_i,
    input  RegIdx inc_idx_i,
    input  logic  wb_en_i,
    input  RegIdx wb_idx_i,
    input  logic  fl_en_i,
    input  RegIdx fl_idx_i,
    input  RegIdx rs1_idx_i,
    input  RegIdx rs2_idx_i,
    input  RegIdx rd_idx_i,
    output logic  rs1_busy_o,
    output logic  rs2_busy_o,
    output logic  rd_full_o
);

    PendCnt pend_q [NUM_REGS];
    PendCnt pend_d [NUM_REGS];
    logic [NUM_REGS-1:0] underflow;

    logic [PEND_W:0] up;
    logic [1:0]      dn;

    // Net change per register: +1 on issue, -1 per writeback and
    // per flushed slot; both decrements may hit the same register.
    always_comb begin
        up        = '0;
        dn        = '0;
        underflow = '0;
        pend_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            up = {{PEND_W{1'b0}},
                  inc_en_i && (inc_idx_i == RegIdx'(r))};
            up = up + {1'b0, pend_q[r]};
            dn = {1'b0, wb_en_i && (wb_idx_i == RegIdx'(r))}
               + {1'b0, fl_en_i && (fl_idx_i == RegIdx'(r))};
            if (up < {{(PEND_W-1){1'b0}}, dn}) begin
                pend_d[r]    = '0;
                underflow[r] = 1'b1;
            end else begin
                pend_d[r] = PendCnt'(up - {{(PEND_W-1){1'b0}}, dn});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

    logic byp1;
    logic byp2;

`ifdef READ_STAGE_CTRL_BYPASS_EN
    // Last outstanding write retires now; datapath forwards it.
    assign byp1 = wb_en_i && (wb_idx_i == rs1_idx_i)
               && (pend_q[rs1_idx_i] == PendCnt'(1));
    assign byp2 = wb_en_i && (wb_idx_i == rs2_idx_i)
               && (pend_q[rs2_idx_i] == PendCnt'(1));
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign rs1_busy_o = (pend_q[rs1_idx_i] != '0) && !byp1;
    assign rs2_busy_o = (pend_q[rs2_idx_i] != '0) && !byp2;
    assign rd_full_o  = (pend_q[rd_idx_i] == PEND_MAX);

    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) (underflow == '0)
    ) else $error("read_scoreboard: decrement of idle counter");

endmodule

// File: rtl/read_stage_ctrl.sv
// Read-stage issue controller: RAW/saturation stall, one-entry
// output slot with backpressure, flush, and stall-cycle counter.
// Ports: in_* (Decode handshake + operands), out_* (Execute slot),
//   wb_* (retire), flush, stall_cnt (wrapping stalled-cycle count).
// Macro READ_STAGE_CTRL_BYPASS_EN enables same-cycle wb forwarding.
module read_stage_ctrl
    import read_stage_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic                 in_rs1_en,
    input  logic                 in_rs2_en,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_rd_we,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_rd_we,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 flush,
    output logic [31:0]          stall_cnt
);

    logic        out_valid_q, out_valid_d;
    RegIdx       out_rd_q, out_rd_d;
    logic        out_rd_we_q, out_rd_we_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic rs1_busy, rs2_busy, rd_full;
    logic haz1, haz2, dst_full, slot_free, issue;
    logic inc_en, wb_en, fl_en;

    assign slot_free = !out_valid_q || out_ready;
    assign haz1      = in_rs1_en && (in_rs1 != '0) && rs1_busy;
    assign haz2      = in_rs2_en && (in_rs2 != '0) && rs2_busy;
    assign dst_full  = in_rd_we && (in_rd != '0) && rd_full;

    assign in_ready = slot_free && !flush && !haz1 && !haz2
                   && !dst_full;
    assign issue    = in_valid && in_ready;

    assign inc_en = issue && in_rd_we && (in_rd != '0);
    assign wb_en  = wb_valid && (wb_rd != '0);
    // A killed, unconsumed slot will never write back.
    assign fl_en  = flush && out_valid_q && !out_ready
                 && out_rd_we_q && (out_rd_q != '0);

    read_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .inc_en_i  (inc_en),
        .inc_idx_i (in_rd),
        .wb_en_i   (wb_en),
        .wb_idx_i  (wb_rd),
        .fl_en_i   (fl_en),
        .fl_idx_i  (out_rd_q),
        .rs1_idx_i (in_rs1),
        .rs2_idx_i (in_rs2),
        .rd_idx_i  (in_rd),
        .rs1_busy_o(rs1_busy),
        .rs2_busy_o(rs2_busy),
        .rd_full_o (rd_full)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_rd_d    = out_rd_q;
        out_rd_we_d = out_rd_we_q;
        stall_cnt_d = stall_cnt_q;
        if (issue) begin
            out_valid_d = 1'b1;
            out_rd_d    = in_rd;
            out_rd_we_d = in_rd_we;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_valid && !in_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_rd_we_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_rd_we_q <= out_rd_we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_rd_we = out_rd_we_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_read_stage_ctrl.sv
// Testbench for read_stage_ctrl: directed scenarios plus a slot
// scoreboard comparing each consumed output against issued inputs.
module tb_read_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rs1_en, in_rs2_en, in_rd_we;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
    } slot_t;

    slot_t exp_q[$];
    slot_t got_e;

    always #5 clk = ~clk;

    read_stage_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_rs1_en(in_rs1_en),
        .in_rs2_en(in_rs2_en),
        .in_rd    (in_rd),
        .in_rd_we (in_rd_we),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_rd   (out_rd),
        .out_rd_we(out_rd_we),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .flush    (flush),
        .stall_cnt(stall_cnt)
    );

    // Slot scoreboard: push on accept, pop on consume/flush.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty out_rd=%0d", out_rd);
                end else begin
                    got_e = exp_q.pop_front();
                    if (out_rd !== got_e.rd || out_rd_we !== got_e.we) begin
                        errors++;
                        $display("FAIL sb_slot got rd=%0d we=%b exp rd=%0d we=%b",
                                 out_rd, out_rd_we, got_e.rd, got_e.we);
                    end
                end
            end else if (out_valid && flush) begin
                if (exp_q.size() != 0) got_e = exp_q.pop_front();
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_rd, in_rd_we});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] r1, input logic e1,
                           input logic [4:0] r2, input logic e2,
                           input logic [4:0] rd, input logic we);
        in_valid  = 1'b1;
        in_rs1    = r1;
        in_rs1_en = e1;
        in_rs2    = r2;
        in_rs2_en = e2;
        in_rd     = rd;
        in_rd_we  = we;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL rst_out_rd got %0d exp 0", out_rd); end
        checks++; if (out_rd_we !== 1'b0) begin errors++; $display("FAIL rst_out_rd_we got %b exp 0", out_rd_we); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall got %0d exp 0", stall_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_raw();
        out_ready = 1'b1;
        present(0, 0, 0, 0, 5, 1);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_first got %b exp 1", in_ready); end
        tick();
        present(5, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall[%0d] got %b exp 0", i, in_ready); end
            tick();
            exp_stall++;
        end
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL raw_stall_cnt got %0d exp 3", stall_cnt); end
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        #1;
`ifdef READ_STAGE_CTRL_BYPASS_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_byp got %b exp 1", in_ready); end
        tick();
        wb_valid = 1'b0;
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle got %b exp 0", in_ready); end
        tick();
        exp_stall++;
        wb_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb got %b exp 1", in_ready); end
        tick();
`endif
        in_valid = 1'b0;
        #1;
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL raw_total got %0d exp %0d", stall_cnt, exp_stall); end
        tick();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        present(0, 0, 0, 0, 7, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sat_issue[%0d] got %b exp 1", i, in_ready); end
            tick();
        end
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sat_full got %b exp 0", in_ready); end
        tick();
        exp_stall++;
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sat_wb_same got %b exp 0", in_ready); end
        tick();
        exp_stall++;
        wb_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sat_fourth got %b exp 1", in_ready); end
        tick();
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sat_refull got %b exp 0", in_ready); end
        in_valid = 1'b0;
        tick();
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        repeat (3) tick();
        wb_valid = 1'b0;
        present(7, 1, 0, 0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sat_drained got %b exp 1", in_ready); end
        in_valid = 1'b0;
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL sat_total got %0d exp %0d", stall_cnt, exp_stall); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        present(0, 0, 0, 0, 10, 1);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first got %b exp 1", in_ready); end
        tick();
        present(0, 0, 0, 0, 11, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (out_rd !== 5'd10 || out_rd_we !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got rd=%0d we=%b exp rd=10 we=1", i, out_rd, out_rd_we); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, in_ready); end
            tick();
            exp_stall++;
        end
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL bp_total got %0d exp %0d", stall_cnt, exp_stall); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
        wb_valid = 1'b1;
        wb_rd    = 5'd10;
        tick();
        wb_rd    = 5'd11;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_x0();
        out_ready = 1'b1;
        present(0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_stream[%0d] got %b exp 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL x0_stall got %0d exp %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        present(0, 0, 0, 0, 9, 1);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_issue got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_block got %b exp 0", in_ready); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_drop got %b exp 0", out_valid); end
        present(9, 1, 0, 0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_rs1 got %b exp 1", in_ready); end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        present(0, 0, 0, 0, 12, 1);
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        present(12, 1, 0, 0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_consumed got %b exp 0", in_ready); end
        in_valid = 1'b0;
        wb_valid = 1'b1;
        wb_rd    = 5'd12;
        tick();
        wb_valid = 1'b0;
        present(0, 0, 0, 0, 13, 1);
        tick();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_second got %b exp 1", in_ready); end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        wb_valid  = 1'b1;
        wb_rd     = 5'd13;
        tick();
        flush    = 1'b0;
        wb_valid = 1'b0;
        present(13, 1, 0, 0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_double got %b exp 1", in_ready); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        present(0, 0, 0, 0, 3, 1);
        tick();
        tick();
        out_ready = 1'b0;
        present(3, 1, 0, 0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_stall got %b exp 0", in_ready); end
        tick();
        exp_stall++;
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL rm_pre got %0d exp %0d", stall_cnt, exp_stall); end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst       = 1'b0;
        exp_stall = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", out_valid); end
        checks++; if (out_rd !== 5'd0 || out_rd_we !== 1'b0) begin errors++; $display("FAIL rm_rd got rd=%0d we=%b exp rd=0 we=0", out_rd, out_rd_we); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rm_stall_cnt got %0d exp 0", stall_cnt); end
        present(3, 1, 0, 0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_rs1 got %b exp 1", in_ready); end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rs1_en = 1'b0;
        in_rs2_en = 1'b0;
        in_rd     = '0;
        in_rd_we  = 1'b0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        flush     = 1'b0;
        test_reset();
        test_raw();
        test_saturation();
        test_backpressure();
        test_x0();
        test_flush();
        test_reset_mid();
        tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
